// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and constants for the DDR write-path arbiter.
//   ADDR_W / LEN_W   : memory command address and length widths
//   DATA_W / KEEP_W  : write data stream widths
//   STATUS_W         : datamover status word width
//   arb_id_w()       : width of a requester id for a given requester count
//                      (ARB_ID_W in the top is derived from it)
package mem_write_arbiter_pkg;

  localparam int ADDR_W   = 64;
  localparam int LEN_W    = 32;
  localparam int DATA_W   = 512;
  localparam int KEEP_W   = 64;
  localparam int STATUS_W = 8;

  // $clog2(2) is 1, but $clog2(1) would be 0; clamp so an id is never zero-width.
  function automatic int arb_id_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [LEN_W-1:0]  length;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_order_fifo.sv
// Order FIFO holding requester ids, one entry per accepted command.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_id (ignored when full)
//   push_id    : requester id to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : id at the head, read combinationally from registered state
//   empty/full : derived from a registered occupancy count
module mem_arb_order_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares one DDR channel write path (command, data, status) between NUM_REQ
// requesters. Commands are granted round-robin; each granted requester id is
// queued twice so the matching data packet and status word are routed back
// in command order.
//
// Handshake: every stream transfers on a cycle where valid && ready are both
// high; a source holds valid and payload stable until that cycle, and valid
// never waits on ready.
//
// Ports:
//   aclk, aresetn                     clock, asynchronous active-low reset
//   s_cmd_*   [NUM_REQ]               requester commands (address, length)
//   s_data_*  [NUM_REQ]               requester write data (data, keep, last)
//   m_status_*[NUM_REQ]               status returned to each requester
//   m_cmd_*                           command to the datamover (registered)
//   m_data_*                          data to the datamover (combinational mux)
//   s_status_*                        status from the datamover
//   busy                              any command outstanding or m_cmd pending
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,

  input  logic [NUM_REQ-1:0]                 s_cmd_valid,
  output logic [NUM_REQ-1:0]                 s_cmd_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]     s_cmd_address,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]      s_cmd_length,

  input  logic [NUM_REQ-1:0]                 s_data_valid,
  output logic [NUM_REQ-1:0]                 s_data_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     s_data_data,
  input  logic [NUM_REQ-1:0][KEEP_W-1:0]     s_data_keep,
  input  logic [NUM_REQ-1:0]                 s_data_last,

  output logic [NUM_REQ-1:0]                 m_status_valid,
  input  logic [NUM_REQ-1:0]                 m_status_ready,
  output logic [NUM_REQ-1:0][STATUS_W-1:0]   m_status_data,

  output logic                               m_cmd_valid,
  input  logic                               m_cmd_ready,
  output logic [ADDR_W-1:0]                  m_cmd_address,
  output logic [LEN_W-1:0]                   m_cmd_length,

  output logic                               m_data_valid,
  input  logic                               m_data_ready,
  output logic [DATA_W-1:0]                  m_data_data,
  output logic [KEEP_W-1:0]                  m_data_keep,
  output logic                               m_data_last,

  input  logic                               s_status_valid,
  output logic                               s_status_ready,
  input  logic [STATUS_W-1:0]                s_status_data,

  output logic                               busy
);

  localparam int ARB_ID_W = arb_id_w(NUM_REQ);
  localparam logic [ARB_ID_W-1:0] LAST_ID = ARB_ID_W'(NUM_REQ - 1);

  logic [ARB_ID_W-1:0] rr;
  logic [ARB_ID_W-1:0] winner;
  logic                win_found;
  logic                accept;

  logic [ARB_ID_W-1:0] d_head;
  logic                d_empty;
  logic                d_full;
  logic                d_pop;
  logic [ARB_ID_W-1:0] st_head;
  logic                st_empty;
  logic                st_full;
  logic                st_pop;

  // Round-robin search starting at rr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    winner    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && s_cmd_valid[idx]) begin
        win_found = 1'b1;
        winner    = ARB_ID_W'(idx);
      end
    end
  end

  // Gating with aresetn keeps every ready low while reset is held, even if
  // a requester keeps its valid asserted through reset.
  assign accept = aresetn && win_found && (!m_cmd_valid || m_cmd_ready)
                  && !d_full && !st_full;

  always_comb begin
    s_cmd_ready = '0;
    if (accept) s_cmd_ready[winner] = 1'b1;
  end

  // Command register: loads on accept, which already covers the
  // drain-and-refill case when m_cmd_ready is high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr            <= '0;
      m_cmd_valid   <= 1'b0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
    end else begin
      if (accept) begin
        m_cmd_valid   <= 1'b1;
        m_cmd_address <= s_cmd_address[winner];
        m_cmd_length  <= s_cmd_length[winner];
        rr            <= (winner == LAST_ID) ? '0 : winner + 1'b1;
      end else if (m_cmd_ready) begin
        m_cmd_valid <= 1'b0;
      end
    end
  end

  mem_arb_order_fifo #(
    .ID_W  (ARB_ID_W),
    .DEPTH (ORDER_DEPTH)
  ) u_data_order (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (accept),
    .push_id (winner),
    .pop     (d_pop),
    .head    (d_head),
    .empty   (d_empty),
    .full    (d_full)
  );

  mem_arb_order_fifo #(
    .ID_W  (ARB_ID_W),
    .DEPTH (ORDER_DEPTH)
  ) u_status_order (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (accept),
    .push_id (winner),
    .pop     (st_pop),
    .head    (st_head),
    .empty   (st_empty),
    .full    (st_full)
  );

  // Data path: only the requester at the head of the data order may pass;
  // everyone else, including early data, is held off with ready low.
  always_comb begin
    m_data_valid = 1'b0;
    m_data_data  = '0;
    m_data_keep  = '0;
    m_data_last  = 1'b0;
    s_data_ready = '0;
    if (!d_empty) begin
      m_data_valid         = s_data_valid[d_head];
      m_data_data          = s_data_data[d_head];
      m_data_keep          = s_data_keep[d_head];
      m_data_last          = s_data_last[d_head];
      s_data_ready[d_head] = m_data_ready;
    end
  end

  assign d_pop = m_data_valid && m_data_ready && m_data_last;

  // Status path: a status with nothing outstanding is stalled, not dropped.
  always_comb begin
    m_status_valid = '0;
    m_status_data  = '0;
    s_status_ready = 1'b0;
    if (!st_empty) begin
      m_status_valid[st_head] = s_status_valid;
      m_status_data[st_head]  = s_status_data;
      s_status_ready          = m_status_ready[st_head];
    end
  end

  assign st_pop = s_status_valid && s_status_ready;

  assign busy = !d_empty || !st_empty || m_cmd_valid;

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;
  import mem_write_arbiter_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int ORDER_DEPTH = 16;

  logic                             aclk;
  logic                             aresetn;
  logic [NUM_REQ-1:0]               s_cmd_valid;
  logic [NUM_REQ-1:0]               s_cmd_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   s_cmd_address;
  logic [NUM_REQ-1:0][LEN_W-1:0]    s_cmd_length;
  logic [NUM_REQ-1:0]               s_data_valid;
  logic [NUM_REQ-1:0]               s_data_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0]   s_data_data;
  logic [NUM_REQ-1:0][KEEP_W-1:0]   s_data_keep;
  logic [NUM_REQ-1:0]               s_data_last;
  logic [NUM_REQ-1:0]               m_status_valid;
  logic [NUM_REQ-1:0]               m_status_ready;
  logic [NUM_REQ-1:0][STATUS_W-1:0] m_status_data;
  logic                             m_cmd_valid;
  logic                             m_cmd_ready;
  logic [ADDR_W-1:0]                m_cmd_address;
  logic [LEN_W-1:0]                 m_cmd_length;
  logic                             m_data_valid;
  logic                             m_data_ready;
  logic [DATA_W-1:0]                m_data_data;
  logic [KEEP_W-1:0]                m_data_keep;
  logic                             m_data_last;
  logic                             s_status_valid;
  logic                             s_status_ready;
  logic [STATUS_W-1:0]              s_status_data;
  logic                             busy;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];

  mem_write_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ORDER_DEPTH (ORDER_DEPTH)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_cmd_valid    (s_cmd_valid),
    .s_cmd_ready    (s_cmd_ready),
    .s_cmd_address  (s_cmd_address),
    .s_cmd_length   (s_cmd_length),
    .s_data_valid   (s_data_valid),
    .s_data_ready   (s_data_ready),
    .s_data_data    (s_data_data),
    .s_data_keep    (s_data_keep),
    .s_data_last    (s_data_last),
    .m_status_valid (m_status_valid),
    .m_status_ready (m_status_ready),
    .m_status_data  (m_status_data),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_address  (m_cmd_address),
    .m_cmd_length   (m_cmd_length),
    .m_data_valid   (m_data_valid),
    .m_data_ready   (m_data_ready),
    .m_data_data    (m_data_data),
    .m_data_keep    (m_data_keep),
    .m_data_last    (m_data_last),
    .s_status_valid (s_status_valid),
    .s_status_ready (s_status_ready),
    .s_status_data  (s_status_data),
    .busy           (busy)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_cmd_valid    = '0;
    s_cmd_address  = '0;
    s_cmd_length   = '0;
    s_data_valid   = '0;
    s_data_data    = '0;
    s_data_keep    = '0;
    s_data_last    = '0;
    m_status_ready = '0;
    m_cmd_ready    = 1'b0;
    m_data_ready   = 1'b0;
    s_status_valid = 1'b0;
    s_status_data  = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) tick();
    aresetn = 1'b1;
    #1;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  int exp_g;
  int accepted;

  initial begin
    // ---- reset values, with requesters driving valid during reset ----
    aresetn = 1'b0;
    clear_inputs();
    s_cmd_valid    = 2'b11;
    s_data_valid   = 2'b11;
    s_status_valid = 1'b1;
    m_cmd_ready    = 1'b1;
    m_data_ready   = 1'b1;
    m_status_ready = 2'b11;
    repeat (2) tick();
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_address", m_cmd_address, 0);
    chk("rst_m_cmd_length", m_cmd_length, 0);
    chk("rst_m_data_valid", m_data_valid, 0);
    chk("rst_s_cmd_ready", s_cmd_ready, 0);
    chk("rst_s_data_ready", s_data_ready, 0);
    chk("rst_m_status_valid", m_status_valid, 0);
    chk("rst_s_status_ready", s_status_ready, 0);
    chk("rst_busy", busy, 0);

    // ---- round-robin alternation, one command per cycle ----
    do_reset();
    m_cmd_ready = 1'b1;
    a0 = 64'h100;
    a1 = 64'h200;
    s_cmd_address[0] = a0;
    s_cmd_address[1] = a1;
    s_cmd_length[0]  = 32'h40;
    s_cmd_length[1]  = 32'h40;
    s_cmd_valid      = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i % 2;
      chk("rr_grant", s_cmd_ready, (exp_g == 1) ? 2'b10 : 2'b01);
      exp_q.push_back((exp_g == 1) ? a1 : a0);
      tick();
      chk("rr_m_cmd_valid", m_cmd_valid, 1);
      chk("rr_m_cmd_address", m_cmd_address, exp_q.pop_front());
      if (exp_g == 1) a1 = a1 + 64'h10;
      else            a0 = a0 + 64'h10;
      s_cmd_address[0] = a0;
      s_cmd_address[1] = a1;
      #1;
    end
    chk("rr_m_cmd_length", m_cmd_length, 32'h40);
    s_cmd_valid = 2'b00;
    tick();
    chk("rr_m_cmd_drained", m_cmd_valid, 0);
    chk("rr_busy_outstanding", busy, 1);

    // ---- data ordering: req1 data offered early is stalled ----
    do_reset();
    m_cmd_ready      = 1'b1;
    m_data_ready     = 1'b1;
    s_cmd_address[0] = 64'hA000;
    s_cmd_length[0]  = 32'd128;
    s_cmd_address[1] = 64'hB000;
    s_cmd_length[1]  = 32'd64;
    s_cmd_valid      = 2'b11;
    s_data_valid     = 2'b10;
    s_data_data[1]   = 512'hB1;
    s_data_keep[1]   = '1;
    s_data_last[1]   = 1'b1;
    #1;
    chk("ord_no_cmd_s_data_ready", s_data_ready, 2'b00);
    chk("ord_no_cmd_m_data_valid", m_data_valid, 0);
    chk("ord_grant0", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = 2'b10;
    #1;
    chk("ord_m_cmd_addr0", m_cmd_address, 64'hA000);
    chk("ord_m_cmd_len0", m_cmd_length, 32'd128);
    chk("ord_req1_stalled", s_data_ready, 2'b01);
    chk("ord_m_data_idle", m_data_valid, 0);
    chk("ord_grant1", s_cmd_ready, 2'b10);
    tick();
    s_cmd_valid    = 2'b00;
    s_data_valid   = 2'b11;
    s_data_data[0] = 512'hA0;
    s_data_keep[0] = '1;
    s_data_last[0] = 1'b0;
    #1;
    chk("ord_m_cmd_addr1", m_cmd_address, 64'hB000);
    chk("ord_beat0_valid", m_data_valid, 1);
    chk("ord_beat0_data", m_data_data, 512'hA0);
    chk("ord_beat0_last", m_data_last, 0);
    chk("ord_beat0_ready", s_data_ready, 2'b01);
    tick();
    s_data_data[0] = 512'hA1;
    s_data_last[0] = 1'b1;
    #1;
    chk("ord_beat1_data", m_data_data, 512'hA1);
    chk("ord_beat1_last", m_data_last, 1);
    tick();
    s_data_valid[0] = 1'b0;
    #1;
    chk("ord_req1_no_gap_valid", m_data_valid, 1);
    chk("ord_req1_data", m_data_data, 512'hB1);
    chk("ord_req1_keep", m_data_keep, {KEEP_W{1'b1}});
    chk("ord_req1_ready", s_data_ready, 2'b10);
    tick();
    s_data_valid = 2'b00;
    #1;
    chk("ord_data_done", m_data_valid, 0);
    chk("ord_busy_status_pending", busy, 1);

    // ---- status routing in command order, stall on requester ready ----
    s_status_valid = 1'b1;
    s_status_data  = 8'h80;
    m_status_ready = 2'b01;
    #1;
    chk("st0_valid", m_status_valid, 2'b01);
    chk("st0_data", m_status_data[0], 8'h80);
    chk("st0_s_ready", s_status_ready, 1);
    tick();
    s_status_data  = 8'h81;
    m_status_ready = 2'b00;
    #1;
    chk("st1_valid", m_status_valid, 2'b10);
    chk("st1_data", m_status_data[1], 8'h81);
    chk("st1_stalled", s_status_ready, 0);
    tick();
    chk("st1_still_stalled", s_status_ready, 0);
    m_status_ready = 2'b10;
    #1;
    chk("st1_s_ready", s_status_ready, 1);
    tick();
    s_status_data = 8'h82;
    #1;
    chk("st_unexpected_ready", s_status_ready, 0);
    chk("st_unexpected_valid", m_status_valid, 2'b00);
    chk("st_idle_busy", busy, 0);
    s_status_valid = 1'b0;
    m_status_ready = 2'b00;

    // ---- order FIFO full: exactly ORDER_DEPTH commands accepted ----
    m_cmd_ready      = 1'b1;
    m_data_ready     = 1'b0;
    s_cmd_address[0] = 64'hC000;
    s_cmd_length[0]  = 32'd64;
    s_cmd_valid      = 2'b01;
    accepted         = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_cmd_ready[0]) accepted++;
      tick();
      #1;
    end
    #1;
    chk("full_accepted", accepted, ORDER_DEPTH);
    chk("full_ready_low", s_cmd_ready, 2'b00);
    s_data_valid   = 2'b01;
    s_data_last[0] = 1'b1;
    m_data_ready   = 1'b1;
    s_status_valid = 1'b1;
    m_status_ready = 2'b01;
    #1;
    chk("full_ready_before_pop", s_cmd_ready, 2'b00);
    tick();
    s_data_valid   = 2'b00;
    s_status_valid = 1'b0;
    #1;
    chk("full_ready_after_pop", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = 2'b00;
    #1;
    chk("full_17th_valid", m_cmd_valid, 1);
    chk("full_17th_addr", m_cmd_address, 64'hC000);

    // ---- asynchronous reset mid-packet ----
    do_reset();
    m_cmd_ready      = 1'b1;
    m_data_ready     = 1'b1;
    s_cmd_address[0] = 64'hD000;
    s_cmd_length[0]  = 32'd256;
    s_cmd_valid      = 2'b01;
    #1;
    tick();
    s_cmd_valid    = 2'b00;
    s_data_valid   = 2'b01;
    s_data_data[0] = 512'hD0;
    s_data_keep[0] = '1;
    s_data_last[0] = 1'b0;
    #1;
    chk("mid_beat0_data", m_data_data, 512'hD0);
    tick();
    s_data_data[0] = 512'hD1;
    tick();
    s_data_data[0]   = 512'hD2;
    s_cmd_address[0] = 64'hE000;
    s_cmd_address[1] = 64'hF000;
    s_cmd_valid      = 2'b11;
    #1;
    chk("mid_beat2_valid", m_data_valid, 1);
    chk("mid_rr_points_1", s_cmd_ready, 2'b10);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_data_valid", m_data_valid, 0);
    chk("mid_rst_s_data_ready", s_data_ready, 2'b00);
    chk("mid_rst_m_cmd_valid", m_cmd_valid, 0);
    chk("mid_rst_m_cmd_address", m_cmd_address, 0);
    chk("mid_rst_m_cmd_length", m_cmd_length, 0);
    chk("mid_rst_s_cmd_ready", s_cmd_ready, 2'b00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_status_ready", s_status_ready, 0);
    tick();
    aresetn      = 1'b1;
    s_data_valid = 2'b00;
    #1;
    chk("post_rst_grant0", s_cmd_ready, 2'b01);
    tick();
    #1;
    chk("post_rst_m_cmd_valid", m_cmd_valid, 1);
    chk("post_rst_m_cmd_addr", m_cmd_address, 64'hE000);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
